// File: rtl/serial_mod_checker.sv
// serial_mod_checker: bit-serial divisibility checker.
// Tracks the running remainder, modulo DIVISOR, of a number received one bit
// per accepted clock. Bits can arrive MSB-first or LSB-first.
// Optional feature macro: SERIAL_MOD_BITCNT_EN adds the frame_len counter/port.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset, dominates all other inputs
//   in_valid  - qualifies start and in
//   start     - accepted bit is the first bit of a new frame
//   in        - serial data bit
//   out       - registered flag: remainder is zero
//   rem       - registered remainder, always < DIVISOR
//   frame_len - accepted bits in current frame, saturating (macro only)
module serial_mod_checker #(
  parameter int unsigned DIVISOR   = 3,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         start,
  input  logic                         in,
  output logic                         out,
  output logic [$clog2(DIVISOR)-1:0]   rem
`ifdef SERIAL_MOD_BITCNT_EN
  ,
  output logic [CNT_W-1:0]             frame_len
`endif
);

  localparam int unsigned REM_W = $clog2(DIVISOR);
  localparam int unsigned SUM_W = REM_W + 1;
  localparam logic [SUM_W-1:0] DIV_S = SUM_W'(DIVISOR);

  // Reject illegal divisors at elaboration time.
  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR must be in 2..255");
  end

  // 2^k mod DIVISOR for the next LSB-first bit; constant-folds away MSB-first.
  logic [REM_W-1:0] weight;
  logic [REM_W-1:0] base_rem;
  logic [REM_W-1:0] base_weight;
  logic [REM_W-1:0] rem_next;
  logic [REM_W-1:0] weight_next;
  logic [SUM_W-1:0] rem_sum;
  logic [SUM_W-1:0] weight_sum;

  // Next-state: both sums are < 2*DIVISOR, so one conditional subtract reduces them.
  always_comb begin
    base_rem    = start ? '0 : rem;
    base_weight = start ? REM_W'(1) : weight;
    rem_sum     = '0;
    if (LSB_FIRST != 0) begin
      rem_sum = {1'b0, base_rem} + (in ? {1'b0, base_weight} : SUM_W'(0));
    end else begin
      rem_sum = {base_rem, in};
    end
    weight_sum  = {base_weight, 1'b0};
    rem_next    = (rem_sum >= DIV_S) ? REM_W'(rem_sum - DIV_S) : REM_W'(rem_sum);
    weight_next = (weight_sum >= DIV_S) ? REM_W'(weight_sum - DIV_S)
                                        : REM_W'(weight_sum);
  end

  // State register; an empty number counts as zero, hence out resets high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem    <= '0;
      out    <= 1'b1;
      weight <= REM_W'(1);
    end else if (in_valid) begin
      rem    <= rem_next;
      out    <= (rem_next == '0);
      weight <= weight_next;
    end
  end

`ifdef SERIAL_MOD_BITCNT_EN
  // Frame bit counter: restarts at 1 on start, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_len <= '0;
    end else if (in_valid) begin
      if (start) begin
        frame_len <= CNT_W'(1);
      end else if (frame_len != {CNT_W{1'b1}}) begin
        frame_len <= frame_len + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_mod_checker.sv
// Testbench for serial_mod_checker: three instances (D=3 MSB, D=5 LSB with
// CNT_W=4, D=7 MSB), directed vector tables plus randomized traffic against
// a modulo-arithmetic reference model.
module tb_serial_mod_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v3, s3, i3, o3;
  logic [1:0] r3;
  logic       v5, s5, i5, o5;
  logic [2:0] r5;
  logic       v7, s7, i7, o7;
  logic [2:0] r7;
`ifdef SERIAL_MOD_BITCNT_EN
  logic [7:0] fl3;
  logic [3:0] fl5;
  logic [7:0] fl7;
`endif

  int total = 0;
  int bad   = 0;

  serial_mod_checker #(.DIVISOR(3), .LSB_FIRST(0), .CNT_W(8)) u3 (
    .clk(clk), .reset(reset), .in_valid(v3), .start(s3), .in(i3),
    .out(o3), .rem(r3)
`ifdef SERIAL_MOD_BITCNT_EN
    , .frame_len(fl3)
`endif
  );

  serial_mod_checker #(.DIVISOR(5), .LSB_FIRST(1), .CNT_W(4)) u5 (
    .clk(clk), .reset(reset), .in_valid(v5), .start(s5), .in(i5),
    .out(o5), .rem(r5)
`ifdef SERIAL_MOD_BITCNT_EN
    , .frame_len(fl5)
`endif
  );

  serial_mod_checker #(.DIVISOR(7), .LSB_FIRST(0), .CNT_W(8)) u7 (
    .clk(clk), .reset(reset), .in_valid(v7), .start(s7), .in(i7),
    .out(o7), .rem(r7)
`ifdef SERIAL_MOD_BITCNT_EN
    , .frame_len(fl7)
`endif
  );

  typedef struct {
    bit s;
    bit b;
    int exp_rem;
    int exp_w;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    v3 = 0; s3 = 0; i3 = 0;
    v5 = 0; s5 = 0; i5 = 0;
    v7 = 0; s7 = 0; i7 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: remainder, current bit weight, frame length.
  int m_div[3]  = '{3, 5, 7};
  bit m_lsb[3]  = '{0, 1, 0};
  int m_max[3]  = '{255, 15, 255};
  int m_rem[3];
  int m_pw[3];
  int m_cnt[3];

  task automatic model_step(input int k, input bit rst, input bit v, input bit s, input bit b);
    if (rst) begin
      m_rem[k] = 0; m_pw[k] = 1; m_cnt[k] = 0;
    end else if (v) begin
      if (s) begin
        m_rem[k] = 0; m_pw[k] = 1; m_cnt[k] = 0;
      end
      if (m_lsb[k]) begin
        m_rem[k] = (m_rem[k] + b * m_pw[k]) % m_div[k];
        m_pw[k]  = (m_pw[k] * 2) % m_div[k];
      end else begin
        m_rem[k] = (m_rem[k] * 2 + b) % m_div[k];
      end
      if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t t3[11];
    vec_t t5[4];
    int   b3[11] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    int   e3[11] = '{0, 0, 1, 0, 1, 0, 1, 2, 2, 2, 1};
    int   val;
    bit   rv[3], rs[3], rb[3], rr;

    for (int i = 0; i < 11; i++) t3[i] = '{(i == 0), b3[i][0], e3[i], 0};
    t5[0] = '{1, 1, 1, 2};
    t5[1] = '{0, 0, 1, 4};
    t5[2] = '{0, 1, 0, 3};
    t5[3] = '{0, 1, 3, 1};

    reset = 1; idle();
    tick(); tick();
    reset = 0;

    // Reset state.
    chk("rst_out3", o3, 1); chk("rst_rem3", r3, 0);
    chk("rst_out5", o5, 1); chk("rst_rem5", r5, 0);
    chk("rst_w5", u5.weight, 1);
    chk("rst_out7", o7, 1); chk("rst_rem7", r7, 0);
`ifdef SERIAL_MOD_BITCNT_EN
    chk("rst_fl3", fl3, 0); chk("rst_fl5", fl5, 0);
`endif

    // D=3 MSB-first frame, value 502.
    val = 0;
    for (int i = 0; i < 11; i++) begin
      v3 = 1; s3 = t3[i].s; i3 = t3[i].b;
      val = val * 2 + b3[i];
      tick();
      chk($sformatf("d3_rem[%0d]", i), r3, t3[i].exp_rem);
      chk($sformatf("d3_out[%0d]", i), o3, (t3[i].exp_rem == 0));
    end
    chk("d3_value_mod", r3, val % 3);
    idle();

    // D=5 LSB-first frame, value 13.
    for (int i = 0; i < 4; i++) begin
      v5 = 1; s5 = t5[i].s; i5 = t5[i].b;
      tick();
      chk($sformatf("d5_rem[%0d]", i), r5, t5[i].exp_rem);
      chk($sformatf("d5_w[%0d]", i), u5.weight, t5[i].exp_w);
    end
    chk("d5_out_final", o5, 0);
`ifdef SERIAL_MOD_BITCNT_EN
    chk("d5_fl", fl5, 4);
`endif

    // Frame restart: start with in=1 alone forms value 1.
    v5 = 1; s5 = 1; i5 = 1;
    tick();
    chk("restart_rem", r5, 1); chk("restart_out", o5, 0);
    chk("restart_w", u5.weight, 2);
`ifdef SERIAL_MOD_BITCNT_EN
    chk("restart_fl", fl5, 1);
`endif
    idle();

    // D=7 MSB-first with a 3-cycle valid gap; start/in ignored while idle.
    v7 = 1; s7 = 1; i7 = 1; tick(); chk("d7_rem0", r7, 1);
    v7 = 1; s7 = 0; i7 = 1; tick(); chk("d7_rem1", r7, 3);
    for (int i = 0; i < 3; i++) begin
      v7 = 0; s7 = 1; i7 = 1;
      tick();
      chk($sformatf("d7_gap_rem[%0d]", i), r7, 3);
      chk($sformatf("d7_gap_out[%0d]", i), o7, 0);
    end
    v7 = 1; s7 = 0; i7 = 1; tick();
    chk("d7_rem_end", r7, 0); chk("d7_out_end", o7, 1);
    idle();

    // Reset mid-frame with a valid bit: reset wins, bit dropped.
    v3 = 1; s3 = 1; i3 = 1; tick(); chk("mid_rem0", r3, 1);
    v3 = 1; s3 = 0; i3 = 0; tick(); chk("mid_rem1", r3, 2);
    reset = 1; v3 = 1; s3 = 0; i3 = 1; v5 = 1; s5 = 0; i5 = 1;
    tick();
    reset = 0; idle();
    chk("mid_rst_rem3", r3, 0); chk("mid_rst_out3", o3, 1);
    chk("mid_rst_rem5", r5, 0); chk("mid_rst_w5", u5.weight, 1);
`ifdef SERIAL_MOD_BITCNT_EN
    chk("mid_rst_fl5", fl5, 0);
`endif
    v3 = 1; s3 = 0; i3 = 1; tick();
    chk("mid_cont_rem3", r3, 1); chk("mid_cont_out3", o3, 0);
    idle();

    // 20 bits without start on D=5 LSB, CNT_W=4: counter saturates at 15.
    m_rem[1] = 0; m_pw[1] = 1; m_cnt[1] = 0;
    for (int i = 0; i < 20; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      v5 = 1; s5 = 0; i5 = b;
      model_step(1, 0, 1, 0, b);
      tick();
      chk($sformatf("sat_rem[%0d]", i), r5, m_rem[1]);
`ifdef SERIAL_MOD_BITCNT_EN
      chk($sformatf("sat_fl[%0d]", i), fl5, m_cnt[1]);
`endif
    end
`ifdef SERIAL_MOD_BITCNT_EN
    chk("sat_fl_final", fl5, 15);
`endif
    idle();

    // Randomized traffic on all three instances against the model.
    reset = 1; tick();
    for (int k = 0; k < 3; k++) model_step(k, 1, 0, 0, 0);
    reset = 0;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 3; k++) begin
        rv[k] = ($urandom_range(0, 3) != 0);
        rs[k] = ($urandom_range(0, 15) == 0);
        rb[k] = 1'($urandom_range(0, 1));
        model_step(k, rr, rv[k], rs[k], rb[k]);
      end
      reset = rr;
      v3 = rv[0]; s3 = rs[0]; i3 = rb[0];
      v5 = rv[1]; s5 = rs[1]; i5 = rb[1];
      v7 = rv[2]; s7 = rs[2]; i7 = rb[2];
      tick();
      chk($sformatf("rnd_rem3[%0d]", c), r3, m_rem[0]);
      chk($sformatf("rnd_out3[%0d]", c), o3, (m_rem[0] == 0));
      chk($sformatf("rnd_rem5[%0d]", c), r5, m_rem[1]);
      chk($sformatf("rnd_out5[%0d]", c), o5, (m_rem[1] == 0));
      chk($sformatf("rnd_w5[%0d]", c), u5.weight, m_pw[1]);
      chk($sformatf("rnd_rem7[%0d]", c), r7, m_rem[2]);
      chk($sformatf("rnd_out7[%0d]", c), o7, (m_rem[2] == 0));
`ifdef SERIAL_MOD_BITCNT_EN
      chk($sformatf("rnd_fl3[%0d]", c), fl3, m_cnt[0]);
      chk($sformatf("rnd_fl5[%0d]", c), fl5, m_cnt[1]);
      chk($sformatf("rnd_fl7[%0d]", c), fl7, m_cnt[2]);
`endif
    end
    reset = 0; idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mod_checker.md
# serial_mod_checker

Bit-serial divisibility checker: consumes one binary digit per accepted clock and tracks the running remainder of the received number modulo a parametrised divisor. It flags whether the number so far is an exact multiple. It generalises the fixed divide-by-3 serial FSM to any divisor from 2 to 255, both bit orders, explicit frame start and a valid qualifier. It sits behind a serial bit source, such as a shift-register front end or a test pattern generator, and feeds a status or compare stage.

## Interface
Parameters:
- DIVISOR, 3, modulus; legal range 2..255; other values are a configuration error.
- LSB_FIRST, 0, bit order: 0 = MSB-first, 1 = LSB-first.
- CNT_W, 8, width of the frame bit counter; used only when SERIAL_MOD_BITCNT_EN is defined.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- in_valid  in  1  qualifies `in` and `start`; no state change when low.
- start  in  1  marks the accepted bit as the first bit of a new frame.
- in  in  1  serial data bit.
- out  out  1  high when the remainder is 0, i.e. the number is a multiple of DIVISOR.
- rem  out  REM_W  current remainder, always < DIVISOR; REM_W = $clog2(DIVISOR).
- frame_len  out  CNT_W  accepted bits in the current frame; present only with the macro.

## Operation
- State registers:
  - rem (REM_W bits).
  - weight (REM_W bits, LSB-first only): holds 2^k mod DIVISOR for the next bit.
  - Optional frame_len counter.
- Accept condition: in_valid == 1 on a rising edge with reset == 0.
- Base value on an accepted bit: if start == 1, the base is rem = 0 and weight = 1; otherwise the base is the current registers.
- MSB-first update: t = 2*base_rem + in. Then t < 2*DIVISOR, so rem_next = t - DIVISOR if t >= DIVISOR, else t. Single conditional subtract; no divider.
- LSB-first update:
  - rem: t = base_rem + (in ? base_weight : 0), then one conditional subtract.
  - weight: w = 2*base_weight, then one conditional subtract.
- Internal sum width is REM_W+1 bits; no overflow is possible.
- out is registered, equal to (rem_next == 0), updated with rem.
- in_valid low: rem, weight, out and frame_len hold. `start` and `in` are ignored.
- The FSM has no explicit state encoding beyond rem; the states are the DIVISOR remainder values.

## Timing
- Reset values:
  - rem = 0
  - out = 1 (an empty number counts as 0, which is divisible)
  - weight = 1
  - frame_len = 0
- Latency: one cycle. Outputs after edge n reflect all bits accepted up to and including edge n.
- Throughput: one bit per clock, no stall, no back-pressure.
- reset asserted together with in_valid: reset wins and the bit is dropped.
- reset mid-frame: the next accepted bit continues from value 0, whether or not start is set.
- start with in_valid: that bit alone forms the new value. For example, start with in = 1 gives rem = 1 and out = 0.
- start without in_valid: ignored.
- frame_len:
  - Set to 1 on an accepted start bit, otherwise +1 per accepted bit.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - The remainder keeps updating past saturation.

## Configuration
- Macro: SERIAL_MOD_BITCNT_EN.
- Defined: the frame_len port and counter exist, with the behaviour given in Timing.
- Undefined: the frame_len port is absent. No counter logic is generated, and all other behaviour is identical.

## Test plan
- DIVISOR=3, MSB-first, start on first bit; bits 0,0,1,1,1,1,1,0,1,1,0:
  - rem after each bit: 0,0,1,0,1,0,1,2,2,2,1.
  - Final state: out = 0, value 502.
- DIVISOR=5, LSB-first, start on first bit; bits 1,0,1,1 (value 13):
  - weight: 1,2,4,3,1.
  - rem: 1,1,0,3.
  - Final out = 0.
- DIVISOR=7, MSB-first; bits 1,1,1 with in_valid deasserted for 3 cycles between the 2nd and 3rd bit:
  - rem holds at 3 during the gap, then goes to 0.
  - out = 1 at the end.
- Frame restart: after the 13-frame from the second scenario, assert start with in = 1:
  - rem = 1, out = 0.
  - frame_len = 1 (macro defined).
- Reset mid-frame: reset asserted with in_valid = 1, in = 1 while rem = 2:
  - Next cycle rem = 0, out = 1, weight = 1, frame_len = 0.
  - The bit is dropped.
- Macro defined, CNT_W = 4: 20 accepted bits without start:
  - frame_len saturates at 15.
  - rem still equals value mod DIVISOR.
